// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types and constants for the two-client multiplier
// sequencer. Holds the controller state encoding, the default datapath
// width and the requester index constants used to address grant vectors.
package mul_share_pkg;

  localparam int WIDTH_DEF = 16;

  // Bit positions of each requester inside two-bit grant/request vectors.
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mul_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit 0 = requester 0)
//   advance    : accept the current grant and move the last-grant pointer
//   gnt[1:0]   : one-hot combinational grant (zero when nothing requests)
// The pointer resets to "requester 1 granted last" so requester 0 wins the
// first contended arbitration.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_r;

  // Grant selection: a lone request wins; on a tie the side not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Last-grant pointer, updated only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_r <= gnt[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one repeated-addition multiplier datapath between
// two requesters. Arbitrates round-robin, loads the winner's operands over
// the single data bus, iterates P <= P + A / B <= B - 1 until B == 0 and
// returns the product with a one-cycle done pulse.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req0/a0/b0, req1/a1/b1   : requester request level and operands
//   gnt0, gnt1               : one-hot grant, held for the whole operation
//   done0, done1             : one-cycle completion pulse to the granted side
//   result                   : product, valid while a done pulse is high
//   busy                     : high whenever the controller is not idle
//   dp_data_in, dp_ld*/clrP/decB : datapath data bus and controls
//   dp_eqz, dp_result        : datapath B==0 flag and P register
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] dp_data_in,
  output logic             dp_ldA,
  output logic             dp_ldB,
  output logic             dp_ldP,
  output logic             dp_clrP,
  output logic             dp_decB,
  input  logic             dp_eqz,
  input  logic [WIDTH-1:0] dp_result
);

  state_t     state_r;
  state_t     state_s;
  logic [1:0] gnt_r;
  logic [1:0] arb_gnt;
  logic       arb_advance;

  // Arbitration only happens while idle; requests arriving while busy wait.
  assign arb_advance = (state_r == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant register: captured on leaving IDLE, cleared when DONE exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r <= 2'b00;
    end else if (state_r == IDLE) begin
      gnt_r <= arb_gnt;
    end else if (state_r == DONE) begin
      gnt_r <= 2'b00;
    end else begin
      gnt_r <= gnt_r;
    end
  end

  // Next-state and Moore output decode; operand mux follows the held grant.
  always_comb begin
    state_s    = state_r;
    dp_data_in = {WIDTH{1'b0}};
    dp_ldA     = 1'b0;
    dp_ldB     = 1'b0;
    dp_ldP     = 1'b0;
    dp_clrP    = 1'b0;
    dp_decB    = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    result     = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_s = LOADA;
        end else begin
          state_s = IDLE;
        end
      end
      LOADA: begin
        dp_data_in = gnt_r[REQ1] ? a1 : a0;
        dp_ldA     = 1'b1;
        state_s    = LOADB;
      end
      LOADB: begin
        dp_data_in = gnt_r[REQ1] ? b1 : b0;
        dp_ldB     = 1'b1;
        dp_clrP    = 1'b1;
        state_s    = ADD;
      end
      ADD: begin
        // eqz comes straight from the B register, so B == 0 on entry
        // (zero multiplier) exits after a single ADD cycle with P = 0.
        if (dp_eqz) begin
          state_s = DONE;
        end else begin
          dp_ldP  = 1'b1;
          dp_decB = 1'b1;
          state_s = ADD;
        end
      end
      DONE: begin
        done0   = gnt_r[REQ0];
        done1   = gnt_r[REQ1];
        result  = dp_result;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign busy = (state_r != IDLE);
  assign gnt0 = gnt_r[REQ0];
  assign gnt1 = gnt_r[REQ1];

endmodule
